regfile_wr_arbiter: RTL and testbench

- Shares the register-file write port between two requesters: port 0 is the pipeline WB stage, port 1 is the long-latency unit (mult/div, late load return).
- Translates each granted request into a lane-aligned 32-bit write with per-byte enables and a one-hot-decodable register index.
- Drives the Enable0..Enable3 / RegWrEn inputs of the per-register byte-lane write cells.
- Fixed priority to port 0, with an anti-starvation counter that forces a port-1 grant.

---
 rtl/regfile_wr_arbiter_pkg.sv | 15 +
 rtl/regfile_wr_arbiter_wr_lane_align.sv | 32 +++
 rtl/regfile_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and encodings for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

    localparam int unsigned DataSz = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        S_PRI0,
        S_FORCE1
    } arbStateE;

endpackage

// File: rtl/regfile_wr_arbiter_wr_lane_align.sv
// Combinational lane alignment: shifts right-justified data into its byte lanes
// and derives the per-byte enables, flagging misaligned or reserved sizes.
module wr_lane_align
    import regfile_wr_arbiter_pkg::*;
(
    input  logic [1:0]        Size,
    input  logic [1:0]        ByteOff,
    input  logic [DataSz-1:0] Data,
    output logic [DataSz-1:0] AlignedData,
    output logic [3:0]        ByteEn,
    output logic              Illegal
);

    always_comb begin
        AlignedData = Data << {ByteOff, 3'b000};
        ByteEn      = '0;
        Illegal     = 1'b0;
        case (Size)
            SZ_BYTE: ByteEn = 4'b0001 << ByteOff;
            SZ_HALF: begin
                if (ByteOff[0]) Illegal = 1'b1;
                else            ByteEn  = ByteOff[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                if (ByteOff != 2'd0) Illegal = 1'b1;
                else                 ByteEn  = '1;
            end
            default: Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-port register-file write arbiter: fixed priority to port 0 with a forced
// port-1 grant after MAX_WAIT held-off cycles. Optional REGWR_ARB_STATS_EN adds ConflictCnt.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [4:0]        Req0Addr,
    input  logic [DataSz-1:0] Req0Data,
    input  logic [1:0]        Req0Size,
    input  logic [1:0]        Req0ByteOff,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [4:0]        Req1Addr,
    input  logic [DataSz-1:0] Req1Data,
    input  logic [1:0]        Req1Size,
    input  logic [1:0]        Req1ByteOff,
    output logic              WrEn,
    output logic [4:0]        WrAddr,
    output logic [DataSz-1:0] WrData,
    output logic [3:0]        WrByteEn,
    output logic              WrErr
`ifdef REGWR_ARB_STATS_EN
    ,
    output logic [15:0]       ConflictCnt
`endif
);

    arbStateE          state;
    logic [WAIT_W-1:0] waitCnt;
    logic              xfer0;
    logic              xfer1;
    logic [4:0]        selAddr;
    logic [DataSz-1:0] selData;
    logic [1:0]        selSize;
    logic [1:0]        selOff;
    logic [DataSz-1:0] alignedData;
    logic [3:0]        alignedBe;
    logic              illegal;
    logic              lastWait;

    // Ready is withheld from both ports while Reset is high so no grant leaks through.
    always_comb begin
        Req0Ready = 1'b0;
        Req1Ready = 1'b0;
        if (!Reset) begin
            case (state)
                S_PRI0: begin
                    Req0Ready = 1'b1;
                    Req1Ready = ~Req0Valid;
                end
                S_FORCE1: Req1Ready = 1'b1;
            endcase
        end
    end

    assign xfer0    = Req0Valid & Req0Ready;
    assign xfer1    = Req1Valid & Req1Ready;
    assign selAddr  = xfer1 ? Req1Addr    : Req0Addr;
    assign selData  = xfer1 ? Req1Data    : Req0Data;
    assign selSize  = xfer1 ? Req1Size    : Req0Size;
    assign selOff   = xfer1 ? Req1ByteOff : Req0ByteOff;
    assign lastWait = (waitCnt == WAIT_W'(MAX_WAIT - 1));

    wr_lane_align uAlign (
        .Size        (selSize),
        .ByteOff     (selOff),
        .Data        (selData),
        .AlignedData (alignedData),
        .ByteEn      (alignedBe),
        .Illegal     (illegal)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_PRI0;
            waitCnt  <= '0;
            WrEn     <= 1'b0;
            WrAddr   <= '0;
            WrData   <= '0;
            WrByteEn <= '0;
            WrErr    <= 1'b0;
        end else begin
            case (state)
                S_PRI0: begin
                    if (Req1Valid && !Req1Ready) begin
                        waitCnt <= waitCnt + 1'b1;
                        if (lastWait) state <= S_FORCE1;
                    end else begin
                        waitCnt <= '0;
                    end
                end
                S_FORCE1: begin
                    state   <= S_PRI0;
                    waitCnt <= '0;
                end
            endcase

            WrEn     <= 1'b0;
            WrByteEn <= '0;
            WrErr    <= 1'b0;
            if (xfer0 || xfer1) begin
                WrAddr <= selAddr;
                WrData <= alignedData;
                // Register 0 is hardwired: accept and drop without flagging an error.
                if (illegal) begin
                    WrErr <= 1'b1;
                end else if (selAddr != 5'd0) begin
                    WrEn     <= 1'b1;
                    WrByteEn <= alignedBe;
                end
            end
        end
    end

`ifdef REGWR_ARB_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            ConflictCnt <= '0;
        else if (Req0Valid && Req1Valid && (ConflictCnt != '1))
            ConflictCnt <= ConflictCnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed requests push expected writes,
// a negedge monitor pops and compares whenever WrEn or WrErr is presented.
module tb_regfile_wr_arbiter;

    typedef struct packed {
        logic        v;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [1:0]  off;
    } rq_t;

    typedef struct packed {
        logic        push;
        logic        wrEn;
        logic        err;
        logic        chkPay;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ex_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req0Valid, Req1Valid;
    logic        Req0Ready, Req1Ready;
    logic [4:0]  Req0Addr, Req1Addr;
    logic [31:0] Req0Data, Req1Data;
    logic [1:0]  Req0Size, Req1Size;
    logic [1:0]  Req0ByteOff, Req1ByteOff;
    logic        WrEn;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic [3:0]  WrByteEn;
    logic        WrErr;
`ifdef REGWR_ARB_STATS_EN
    logic [15:0] ConflictCnt;
    int unsigned confModel = 0;
`endif

    int unsigned nCmp = 0;
    int unsigned nErr = 0;
    ex_t         sbQ[$];

    always #5 Clk = ~Clk;

    regfile_wr_arbiter #(.MAX_WAIT(4), .WAIT_W(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req0Valid   (Req0Valid),
        .Req0Ready   (Req0Ready),
        .Req0Addr    (Req0Addr),
        .Req0Data    (Req0Data),
        .Req0Size    (Req0Size),
        .Req0ByteOff (Req0ByteOff),
        .Req1Valid   (Req1Valid),
        .Req1Ready   (Req1Ready),
        .Req1Addr    (Req1Addr),
        .Req1Data    (Req1Data),
        .Req1Size    (Req1Size),
        .Req1ByteOff (Req1ByteOff),
        .WrEn        (WrEn),
        .WrAddr      (WrAddr),
        .WrData      (WrData),
        .WrByteEn    (WrByteEn),
        .WrErr       (WrErr)
`ifdef REGWR_ARB_STATS_EN
        ,
        .ConflictCnt (ConflictCnt)
`endif
    );

    function automatic rq_t rq(input logic [4:0] a, input logic [31:0] d,
                               input logic [1:0] s, input logic [1:0] o);
        rq_t r;
        r.v = 1'b1; r.addr = a; r.data = d; r.size = s; r.off = o;
        return r;
    endfunction

    function automatic ex_t wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        ex_t e;
        e.push = 1'b1; e.wrEn = 1'b1; e.err = 1'b0; e.chkPay = 1'b1;
        e.addr = a; e.data = d; e.be = be;
        return e;
    endfunction

    function automatic ex_t errX();
        ex_t e;
        e = '0;
        e.push = 1'b1; e.err = 1'b1;
        return e;
    endfunction

    localparam rq_t NOREQ = '0;
    localparam ex_t NONE  = '0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive requests, check Ready, and queue expected writes for accepted ports.
    task automatic step(input rq_t q0, input ex_t e0, input rq_t q1, input ex_t e1,
                        input logic rst, input logic er0, input logic er1);
        @(posedge Clk);
        #1;
        Reset       = rst;
        Req0Valid   = q0.v;  Req0Addr = q0.addr; Req0Data = q0.data;
        Req0Size    = q0.size; Req0ByteOff = q0.off;
        Req1Valid   = q1.v;  Req1Addr = q1.addr; Req1Data = q1.data;
        Req1Size    = q1.size; Req1ByteOff = q1.off;
        #1;
        cmp("Req0Ready", 64'(Req0Ready), 64'(er0));
        cmp("Req1Ready", 64'(Req1Ready), 64'(er1));
`ifdef REGWR_ARB_STATS_EN
        cmp("ConflictCnt", 64'(ConflictCnt), 64'(confModel));
        if (rst) confModel = 0;
        else if (q0.v && q1.v && confModel < 65535) confModel++;
`endif
        if (er0 && q0.v && e0.push) sbQ.push_back(e0);
        if (er1 && q1.v && e1.push) sbQ.push_back(e1);
    endtask

    task automatic checkZero(input string tag);
        cmp({tag, ".WrEn"},     64'(WrEn),     64'd0);
        cmp({tag, ".WrAddr"},   64'(WrAddr),   64'd0);
        cmp({tag, ".WrData"},   64'(WrData),   64'd0);
        cmp({tag, ".WrByteEn"}, 64'(WrByteEn), 64'd0);
        cmp({tag, ".WrErr"},    64'(WrErr),    64'd0);
    endtask

    always @(negedge Clk) begin
        if (WrEn === 1'b1 || WrErr === 1'b1) begin
            if (sbQ.size() == 0) begin
                cmp("unexpected_write", {WrErr, WrEn, 26'd0, WrAddr, WrByteEn, WrData}, 64'd0);
            end else begin
                ex_t e;
                e = sbQ.pop_front();
                cmp("WrEn",     64'(WrEn),     64'(e.wrEn));
                cmp("WrErr",    64'(WrErr),    64'(e.err));
                cmp("WrByteEn", 64'(WrByteEn), 64'(e.be));
                if (e.chkPay) begin
                    cmp("WrAddr", 64'(WrAddr), 64'(e.addr));
                    cmp("WrData", 64'(WrData), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rq_t p1;
        Reset = 1'b1;
        Req0Valid = 1'b0; Req0Addr = '0; Req0Data = '0; Req0Size = '0; Req0ByteOff = '0;
        Req1Valid = 1'b0; Req1Addr = '0; Req1Data = '0; Req1Size = '0; Req1ByteOff = '0;

        step(NOREQ, NONE, NOREQ, NONE, 1'b1, 1'b0, 1'b0);
        step(NOREQ, NONE, NOREQ, NONE, 1'b1, 1'b0, 1'b0);
        checkZero("reset");
        step(NOREQ, NONE, NOREQ, NONE, 1'b0, 1'b1, 1'b1);

        // Single-port alignment and drop cases
        step(rq(5, 32'hDEADBEEF, 2'b10, 2'd0), wr(5, 32'hDEADBEEF, 4'b1111), NOREQ, NONE, 1'b0, 1'b1, 1'b0);
        step(NOREQ, NONE, rq(9, 32'h000000A5, 2'b00, 2'd3), wr(9, 32'hA5000000, 4'b1000), 1'b0, 1'b1, 1'b1);
        step(rq(7, 32'h00000055, 2'b01, 2'd1), errX(), NOREQ, NONE, 1'b0, 1'b1, 1'b0);
        step(rq(0, 32'hFFFFFFFF, 2'b10, 2'd0), NONE, NOREQ, NONE, 1'b0, 1'b1, 1'b0);
        step(rq(8, 32'h12345678, 2'b00, 2'd1), wr(8, 32'h34567800, 4'b0010), NOREQ, NONE, 1'b0, 1'b1, 1'b0);
        step(NOREQ, NONE, rq(4, 32'h0000ABCD, 2'b11, 2'd0), errX(), 1'b0, 1'b1, 1'b1);
        step(rq(6, 32'hCAFEF00D, 2'b10, 2'd2), errX(), NOREQ, NONE, 1'b0, 1'b1, 1'b0);
        step(NOREQ, NONE, rq(3, 32'h00001234, 2'b01, 2'd2), wr(3, 32'h12340000, 4'b1100), 1'b0, 1'b1, 1'b1);
        step(rq(31, 32'h000000C3, 2'b00, 2'd2), wr(31, 32'h00C30000, 4'b0100), NOREQ, NONE, 1'b0, 1'b1, 1'b0);
        step(NOREQ, NONE, NOREQ, NONE, 1'b0, 1'b1, 1'b1);

        // Starvation: four port-0 grants, forced port-1 grant, port 0 resumes
        p1 = rq(20, 32'h11112222, 2'b10, 2'd0);
        step(rq(10, 32'h0000000A, 2'b00, 2'd0), wr(10, 32'h0000000A, 4'b0001), p1, wr(20, 32'h11112222, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(11, 32'h0000000B, 2'b00, 2'd1), wr(11, 32'h00000B00, 4'b0010), p1, wr(20, 32'h11112222, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(12, 32'h0000C0DE, 2'b01, 2'd0), wr(12, 32'h0000C0DE, 4'b0011), p1, wr(20, 32'h11112222, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(13, 32'h13131313, 2'b10, 2'd0), wr(13, 32'h13131313, 4'b1111), p1, wr(20, 32'h11112222, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(14, 32'h14141414, 2'b10, 2'd0), wr(14, 32'h14141414, 4'b1111), p1, wr(20, 32'h11112222, 4'b1111), 1'b0, 1'b0, 1'b1);
        step(rq(14, 32'h14141414, 2'b10, 2'd0), wr(14, 32'h14141414, 4'b1111), NOREQ, NONE, 1'b0, 1'b1, 1'b0);
        step(NOREQ, NONE, NOREQ, NONE, 1'b0, 1'b1, 1'b1);

        // Reset lands on the forced-grant cycle; arbitration restarts from counter 0
        p1 = rq(25, 32'h25252525, 2'b10, 2'd0);
        step(rq(21, 32'h21212121, 2'b10, 2'd0), wr(21, 32'h21212121, 4'b1111), p1, wr(25, 32'h25252525, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(22, 32'h22222222, 2'b10, 2'd0), wr(22, 32'h22222222, 4'b1111), p1, wr(25, 32'h25252525, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(23, 32'h23232323, 2'b10, 2'd0), wr(23, 32'h23232323, 4'b1111), p1, wr(25, 32'h25252525, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(24, 32'h24242424, 2'b10, 2'd0), wr(24, 32'h24242424, 4'b1111), p1, wr(25, 32'h25252525, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(26, 32'h26262626, 2'b10, 2'd0), wr(26, 32'h26262626, 4'b1111), p1, wr(25, 32'h25252525, 4'b1111), 1'b1, 1'b0, 1'b0);
        step(rq(26, 32'h26262626, 2'b10, 2'd0), wr(26, 32'h26262626, 4'b1111), p1, wr(25, 32'h25252525, 4'b1111), 1'b0, 1'b1, 1'b0);
        checkZero("midreset");
        step(rq(27, 32'h27272727, 2'b10, 2'd0), wr(27, 32'h27272727, 4'b1111), p1, wr(25, 32'h25252525, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(28, 32'h28282828, 2'b10, 2'd0), wr(28, 32'h28282828, 4'b1111), p1, wr(25, 32'h25252525, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(29, 32'h29292929, 2'b10, 2'd0), wr(29, 32'h29292929, 4'b1111), p1, wr(25, 32'h25252525, 4'b1111), 1'b0, 1'b1, 1'b0);
        step(rq(30, 32'h30303030, 2'b10, 2'd0), wr(30, 32'h30303030, 4'b1111), p1, wr(25, 32'h25252525, 4'b1111), 1'b0, 1'b0, 1'b1);
        step(rq(30, 32'h30303030, 2'b10, 2'd0), wr(30, 32'h30303030, 4'b1111), NOREQ, NONE, 1'b0, 1'b1, 1'b0);
        step(NOREQ, NONE, NOREQ, NONE, 1'b0, 1'b1, 1'b1);
        step(NOREQ, NONE, NOREQ, NONE, 1'b0, 1'b1, 1'b1);
        step(NOREQ, NONE, NOREQ, NONE, 1'b0, 1'b1, 1'b1);

        cmp("scoreboard_empty", 64'(sbQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
